uart_loopback_fifo: RTL and testbench
=====================================

// Module: uart_loopback_fifo
// PURPOSE
//  Next-generation UART top: parametrised RX and TX engines with a FIFO on each side.
//  Supports runtime baud divisor, none/even/odd parity, 1 or 2 stop bits, and sticky error status.
//  loop_en=1: received frames are retransmitted on tx_out with no host involvement.
//  loop_en=0: a host pushes TX bytes and pops RX bytes over valid/ready.
// PARAMETERS
//  DATA_W      8   data bits per frame, legal 5..8, sent and received LSB first
//  FIFO_DEPTH  16  entries per FIFO; power of 2, >=2
//  DIV_W       13  width of clk_per_bit
// PORTS
//  clk           in   1                      system clock, all logic on rising edge
//  rst           in   1                      synchronous, active-high reset
//  clk_per_bit   in   DIV_W                  clocks per bit; values <4 treated as 4
//  parity_en     in   1                      1 = parity bit present
//  parity_odd    in   1                      1 = odd parity, 0 = even parity
//  stop2         in   1                      1 = two stop bits
//  loop_en       in   1                      1 = RX FIFO drains into TX FIFO
//  err_clr       in   1                      clears sticky error flags
//  rx_in         in   1                      serial input, asynchronous, idle high
//  tx_out        out  1                      serial output, idle high
//  wr_valid      in   1                      host TX byte valid
//  wr_data       in   DATA_W                 host TX byte
//  wr_ready      out  1                      TX FIFO not full && !loop_en
//  rd_valid      out  1                      RX FIFO not empty && !loop_en
//  rd_data       out  DATA_W                 RX FIFO head; valid only while rd_valid
//  rd_ready      in   1                      host pops RX byte
//  rx_count      out  $clog2(FIFO_DEPTH)+1   RX FIFO occupancy
//  tx_busy       out  1                      TX FSM not IDLE, or TX FIFO not empty
//  parity_error  out  1                      sticky
//  frame_error   out  1                      sticky
//  overrun_error out  1                      sticky
// BEHAVIOUR
//  Reset: tx_out=1. FIFOs empty, so rd_valid=0 and rx_count=0. tx_busy=0. All error flags=0.
//    Both FSMs go to IDLE. Applies mid-frame: tx_out is high from the next edge and any partial frame is lost.
//  Config (clk_per_bit, parity_en, parity_odd, stop2): latched by each FSM when it leaves IDLE.
//    Changes mid-frame do not affect the frame in progress.
//  RX input: rx_in passes through a 2-flop synchroniser before use.
//  RX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//    IDLE -> START on the synchronised falling edge.
//    START samples at clk_per_bit/2 (integer divide); if the line is high, false start, return to IDLE.
//    Each later bit is sampled clk_per_bit clocks after the previous sample.
//    PARITY is skipped when parity_en=0.
//    STOP samples 1 or 2 stop bits.
//  RX frame checks:
//    Any stop sample low: frame_error set, byte discarded.
//    Parity mismatch (even: XOR of data^parity==0; odd: ==1): parity_error set, byte discarded.
//    Good frame: byte pushed into the RX FIFO on the clock after the last stop sample.
//    Good frame with RX FIFO full and no pop that cycle: overrun_error set, byte dropped.
//    Full FIFO with a pop in the same cycle: the push is accepted.
//  Error flags: cleared by err_clr or rst. If err_clr and a set event occur in the same cycle, set wins.
//  Loopback: when loop_en=1, RX FIFO and TX FIFO both non-empty-safe (RX non-empty, TX not full),
//    one byte per clock moves from RX FIFO to TX FIFO. Host ports are gated off (wr_ready=0, rd_valid=0).
//  TX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//    Leaves IDLE when the TX FIFO is non-empty, popping the head byte.
//    tx_out goes low on the clock after the pop.
//    Each bit is held exactly clk_per_bit clocks; stop is 1 or 2 bits high.
//    Back-to-back frames follow with no extra idle bit.
//  FIFOs: wrap-around pointers with an extra MSB for full/empty detection.
//    Push and pop allowed in the same cycle, including when full or empty.
//    Pop on empty and push on full (without a pop) are ignored.
//    Same-cycle push and pop when empty: the pushed byte is visible on the next clock.
// TESTING
//  rst=1 for 3 clocks with rx_in=0 -> tx_out=1, rd_valid=0, rx_count=0, all error flags 0.
//  loop_en=0, clk_per_bit=16, 8N1, push 0xA5 -> tx_out: start 0, bits 1,0,1,0,0,1,0,1, stop 1;
//    each bit held 16 clocks; tx_busy falls after the stop bit.
//  rx_in sends 0x3C, even parity, parity bit=1 -> parity_error=1, rx_count stays 0;
//    then err_clr pulse -> parity_error=0.
//  loop_en=1, 8O2, rx_in sends 0x00, 0xFF, 0x81 -> tx_out repeats the same three frames with odd parity
//    and two stop bits; rd_valid stays 0.
//  loop_en=0, rd_ready=0, send FIFO_DEPTH+1 frames -> rx_count=16, overrun_error=1,
//    the first 16 bytes are read back in order.
//  rx_in low pulse of 4 clocks at clk_per_bit=16 -> false start, no push, no error flags set.

Source files
------------

// File: rtl/uart_loopback_fifo_if.sv
// Host byte-stream bundle: TX bytes in (wr_*), RX bytes out (rd_*), both valid/ready.
// Master is the host side; slave is the UART.
interface uart_loopback_fifo_if #(
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/uart_loopback_fifo.sv
// UART with RX/TX FIFOs and optional RX->TX loopback; RX byte lands in its FIFO 1 clk after the last stop sample.
// Backpressure: host wr_ready/rd_valid follow FIFO full/empty (gated off in loopback); a full RX FIFO drops and flags overrun.
module uart_loopback_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              clk_per_bit,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic                          loop_en,
    input  logic                          err_clr,
    input  logic                          rx_in,
    output logic                          tx_out,
    uart_loopback_fifo_if.slave           host,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          tx_busy,
    output logic                          parity_error,
    output logic                          frame_error,
    output logic                          overrun_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W);

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic             par_en;
        logic             par_odd;
        logic             stop2;
    } cfg_t;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    cfg_t cfg_now;
    always_comb begin
        cfg_now.div     = (clk_per_bit < DIV_W'(4)) ? DIV_W'(4) : clk_per_bit;
        cfg_now.par_en  = parity_en;
        cfg_now.par_odd = parity_odd;
        cfg_now.stop2   = stop2;
    end

    // Extra pointer MSB distinguishes full from empty.
    logic [DATA_W-1:0] rxq_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] txq_mem [FIFO_DEPTH];
    logic [AW:0]       rxq_wp, rxq_rp, txq_wp, txq_rp;
    logic              rxq_empty, rxq_full, rxq_push, rxq_pop, rxq_wr, rxq_rd;
    logic              txq_empty, txq_full, txq_push, txq_pop, txq_wr, txq_rd;
    logic [DATA_W-1:0] rxq_head, txq_head, txq_din;

    assign rxq_empty = (rxq_wp == rxq_rp);
    assign rxq_full  = (rxq_wp[AW] != rxq_rp[AW]) && (rxq_wp[AW-1:0] == rxq_rp[AW-1:0]);
    assign rxq_rd    = rxq_pop && !rxq_empty;
    assign rxq_wr    = rxq_push && (!rxq_full || rxq_pop);
    assign rxq_head  = rxq_mem[rxq_rp[AW-1:0]];
    assign rx_count  = rxq_wp - rxq_rp;

    assign txq_empty = (txq_wp == txq_rp);
    assign txq_full  = (txq_wp[AW] != txq_rp[AW]) && (txq_wp[AW-1:0] == txq_rp[AW-1:0]);
    assign txq_rd    = txq_pop && !txq_empty;
    assign txq_wr    = txq_push && (!txq_full || txq_pop);
    assign txq_head  = txq_mem[txq_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            rxq_wp <= '0;
            rxq_rp <= '0;
            txq_wp <= '0;
            txq_rp <= '0;
        end else begin
            if (rxq_wr) rxq_wp <= rxq_wp + (AW+1)'(1);
            if (rxq_rd) rxq_rp <= rxq_rp + (AW+1)'(1);
            if (txq_wr) txq_wp <= txq_wp + (AW+1)'(1);
            if (txq_rd) txq_rp <= txq_rp + (AW+1)'(1);
        end
    end

    logic [DATA_W-1:0] rx_shift;
    always_ff @(posedge clk) begin
        if (rxq_wr) rxq_mem[rxq_wp[AW-1:0]] <= rx_shift;
        if (txq_wr) txq_mem[txq_wp[AW-1:0]] <= txq_din;
    end

    logic lb_move;
    assign lb_move       = loop_en && !rxq_empty && !txq_full;
    assign host.rd_valid = !rxq_empty && !loop_en;
    assign host.rd_data  = rxq_head;
    assign host.wr_ready = !txq_full && !loop_en;
    assign rxq_pop       = loop_en ? lb_move : (host.rd_valid && host.rd_ready);
    assign txq_push      = loop_en ? lb_move : (host.wr_valid && host.wr_ready);
    assign txq_din       = loop_en ? rxq_head : host.wr_data;

    // ---------------- RX ----------------
    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    state_t            rx_state, rx_state_nxt;
    cfg_t              rx_cfg, rx_cfg_nxt;
    logic [DIV_W-1:0]  rx_cnt, rx_cnt_nxt;
    logic [BW-1:0]     rx_bit, rx_bit_nxt;
    logic [DATA_W-1:0] rx_shift_nxt;
    logic              rx_par, rx_par_nxt, rx_stop_idx, rx_stop_idx_nxt, rx_ferr, rx_ferr_nxt;
    logic              rx_push_nxt, rx_perr_evt, rx_perr_evt_nxt, rx_ferr_evt, rx_ferr_evt_nxt;
    logic              rx_tick, rx_stop_bad, rx_par_bad;

    assign rx_tick     = (rx_cnt == rx_cfg.div - DIV_W'(1));
    assign rx_stop_bad = rx_ferr || !rx_s2;
    assign rx_par_bad  = rx_cfg.par_en && (rx_par != rx_cfg.par_odd);

    always_comb begin
        rx_state_nxt    = rx_state;
        rx_cfg_nxt      = rx_cfg;
        rx_cnt_nxt      = rx_cnt + DIV_W'(1);
        rx_bit_nxt      = rx_bit;
        rx_shift_nxt    = rx_shift;
        rx_par_nxt      = rx_par;
        rx_stop_idx_nxt = rx_stop_idx;
        rx_ferr_nxt     = rx_ferr;
        rx_push_nxt     = 1'b0;
        rx_perr_evt_nxt = 1'b0;
        rx_ferr_evt_nxt = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_prev && !rx_s2) begin
                    rx_state_nxt = S_START;
                    rx_cfg_nxt   = cfg_now;
                end
            end
            S_START: if (rx_cnt == (rx_cfg.div >> 1) - DIV_W'(1)) begin
                rx_cnt_nxt   = '0;
                rx_bit_nxt   = '0;
                rx_par_nxt   = 1'b0;
                rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_tick) begin
                rx_cnt_nxt   = '0;
                rx_shift_nxt = {rx_s2, rx_shift[DATA_W-1:1]};
                rx_par_nxt   = rx_par ^ rx_s2;
                rx_bit_nxt   = rx_bit + BW'(1);
                if (rx_bit == BW'(DATA_W-1)) begin
                    rx_state_nxt    = rx_cfg.par_en ? S_PARITY : S_STOP;
                    rx_stop_idx_nxt = 1'b0;
                    rx_ferr_nxt     = 1'b0;
                end
            end
            S_PARITY: if (rx_tick) begin
                rx_cnt_nxt      = '0;
                rx_par_nxt      = rx_par ^ rx_s2;
                rx_state_nxt    = S_STOP;
                rx_stop_idx_nxt = 1'b0;
                rx_ferr_nxt     = 1'b0;
            end
            S_STOP: if (rx_tick) begin
                rx_cnt_nxt = '0;
                if (rx_cfg.stop2 && !rx_stop_idx) begin
                    rx_stop_idx_nxt = 1'b1;
                    rx_ferr_nxt     = rx_stop_bad;
                end else begin
                    rx_state_nxt    = S_IDLE;
                    rx_ferr_evt_nxt = rx_stop_bad;
                    rx_perr_evt_nxt = rx_par_bad;
                    rx_push_nxt     = !rx_stop_bad && !rx_par_bad;
                end
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= S_IDLE;
            rx_cfg      <= '0;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
            rx_stop_idx <= 1'b0;
            rx_ferr     <= 1'b0;
            rxq_push    <= 1'b0;
            rx_perr_evt <= 1'b0;
            rx_ferr_evt <= 1'b0;
        end else begin
            rx_state    <= rx_state_nxt;
            rx_cfg      <= rx_cfg_nxt;
            rx_cnt      <= rx_cnt_nxt;
            rx_bit      <= rx_bit_nxt;
            rx_shift    <= rx_shift_nxt;
            rx_par      <= rx_par_nxt;
            rx_stop_idx <= rx_stop_idx_nxt;
            rx_ferr     <= rx_ferr_nxt;
            rxq_push    <= rx_push_nxt;
            rx_perr_evt <= rx_perr_evt_nxt;
            rx_ferr_evt <= rx_ferr_evt_nxt;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_error  <= 1'b0;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (rx_perr_evt)                          parity_error  <= 1'b1;
            else if (err_clr)                         parity_error  <= 1'b0;
            if (rx_ferr_evt)                          frame_error   <= 1'b1;
            else if (err_clr)                         frame_error   <= 1'b0;
            if (rxq_push && rxq_full && !rxq_pop)     overrun_error <= 1'b1;
            else if (err_clr)                         overrun_error <= 1'b0;
        end
    end

    // ---------------- TX ----------------
    state_t            tx_state, tx_state_nxt;
    cfg_t              tx_cfg, tx_cfg_nxt;
    logic [DIV_W-1:0]  tx_cnt, tx_cnt_nxt;
    logic [BW-1:0]     tx_bit, tx_bit_nxt;
    logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
    logic              tx_par, tx_par_nxt, tx_stop_idx, tx_stop_idx_nxt, tx_out_nxt;
    logic              tx_tick, tx_load;

    assign tx_tick = (tx_cnt == tx_cfg.div - DIV_W'(1));
    assign tx_busy = (tx_state != S_IDLE) || !txq_empty;

    always_comb begin
        tx_state_nxt    = tx_state;
        tx_cfg_nxt      = tx_cfg;
        tx_cnt_nxt      = tx_cnt + DIV_W'(1);
        tx_bit_nxt      = tx_bit;
        tx_shift_nxt    = tx_shift;
        tx_par_nxt      = tx_par;
        tx_stop_idx_nxt = tx_stop_idx;
        tx_load         = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_nxt = '0;
                tx_load    = !txq_empty;
            end
            S_START: if (tx_tick) begin
                tx_cnt_nxt   = '0;
                tx_bit_nxt   = '0;
                tx_state_nxt = S_DATA;
            end
            S_DATA: if (tx_tick) begin
                tx_cnt_nxt   = '0;
                tx_par_nxt   = tx_par ^ tx_shift[0];
                tx_shift_nxt = tx_shift >> 1;
                tx_bit_nxt   = tx_bit + BW'(1);
                if (tx_bit == BW'(DATA_W-1)) begin
                    tx_state_nxt    = tx_cfg.par_en ? S_PARITY : S_STOP;
                    tx_stop_idx_nxt = 1'b0;
                end
            end
            S_PARITY: if (tx_tick) begin
                tx_cnt_nxt      = '0;
                tx_state_nxt    = S_STOP;
                tx_stop_idx_nxt = 1'b0;
            end
            S_STOP: if (tx_tick) begin
                tx_cnt_nxt = '0;
                if (tx_cfg.stop2 && !tx_stop_idx) tx_stop_idx_nxt = 1'b1;
                else if (!txq_empty)              tx_load         = 1'b1;
                else                              tx_state_nxt    = S_IDLE;
            end
            default: tx_state_nxt = S_IDLE;
        endcase
        // Loading straight from STOP gives back-to-back frames with no idle gap.
        if (tx_load) begin
            tx_state_nxt = S_START;
            tx_cnt_nxt   = '0;
            tx_cfg_nxt   = cfg_now;
            tx_shift_nxt = txq_head;
            tx_par_nxt   = 1'b0;
        end
        txq_pop = tx_load;
        case (tx_state_nxt)
            S_START:  tx_out_nxt = 1'b0;
            S_DATA:   tx_out_nxt = tx_shift_nxt[0];
            S_PARITY: tx_out_nxt = tx_par_nxt ^ tx_cfg.par_odd;
            default:  tx_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= S_IDLE;
            tx_cfg      <= '0;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_stop_idx <= 1'b0;
            tx_out      <= 1'b1;
        end else begin
            tx_state    <= tx_state_nxt;
            tx_cfg      <= tx_cfg_nxt;
            tx_cnt      <= tx_cnt_nxt;
            tx_bit      <= tx_bit_nxt;
            tx_shift    <= tx_shift_nxt;
            tx_par      <= tx_par_nxt;
            tx_stop_idx <= tx_stop_idx_nxt;
            tx_out      <= tx_out_nxt;
        end
    end
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed bench for uart_loopback_fifo: serial frames driven/captured at 16 clocks per bit.
// Outputs sampled on negedges; inputs driven on negedges.
module tb_uart_loopback_fifo;
    logic        clk;
    logic        rst;
    logic [12:0] clk_per_bit;
    logic        parity_en, parity_odd, stop2, loop_en, err_clr;
    logic        rx_in;
    logic        tx_out;
    logic [4:0]  rx_count;
    logic        tx_busy, parity_error, frame_error, overrun_error;

    int checks   = 0;
    int failures = 0;

    uart_loopback_fifo_if #(.DATA_W(8)) bus ();

    uart_loopback_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .clk_per_bit   (clk_per_bit),
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .stop2         (stop2),
        .loop_en       (loop_en),
        .err_clr       (err_clr),
        .rx_in         (rx_in),
        .tx_out        (tx_out),
        .host          (bus),
        .rx_count      (rx_count),
        .tx_busy       (tx_busy),
        .parity_error  (parity_error),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one serial frame onto rx_in, bits[0] first.
    task automatic send(input logic [11:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_in = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    // Wait for a start bit on tx_out, then sample each bit at its centre; obs[0] is the start bit.
    task automatic capture(input int nbits, output logic [11:0] obs);
        int waited;
        waited = 0;
        obs    = '0;
        while (tx_out !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("tx_start_seen", 32'(waited < 2000), 32'd1);
        repeat (8) @(negedge clk);
        obs[0] = tx_out;
        for (int i = 1; i < nbits; i++) begin
            repeat (16) @(negedge clk);
            obs[i] = tx_out;
        end
    endtask

    logic [11:0] obs_a, obs_b, obs_c, fr;
    logic [7:0]  b;
    logic        rdv_seen;

    initial begin
        rst = 1'b1; rx_in = 1'b0; clk_per_bit = 13'd16;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; loop_en = 1'b0; err_clr = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;

        // Reset with the line held low
        repeat (3) @(negedge clk);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_errors", {parity_error, frame_error, overrun_error}, 0);
        rst = 1'b0; rx_in = 1'b1;
        repeat (20) @(negedge clk);

        // Host TX 0xA5, 8N1; divisor change mid-frame must not matter
        chk("wr_ready_idle", bus.wr_ready, 1);
        bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        chk("tx_busy_after_push", tx_busy, 1);
        @(negedge clk);
        clk_per_bit = 13'd8;
        capture(10, obs_a);
        chk("tx_frame_A5", obs_a[9:0], 10'h34A);
        repeat (7) @(negedge clk);
        chk("tx_busy_last_stop_clk", tx_busy, 1);
        @(negedge clk);
        chk("tx_busy_after_stop", tx_busy, 0);
        clk_per_bit = 13'd16;

        // RX 0x3C with even parity but parity bit 1
        parity_en = 1'b1; parity_odd = 1'b0;
        send(12'h678, 11);
        repeat (4) @(negedge clk);
        chk("perr_set", parity_error, 1);
        chk("perr_no_push", rx_count, 0);
        chk("perr_no_ferr", frame_error, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("perr_cleared", parity_error, 0);

        // Loopback, 8O2: three frames echoed on tx_out, host read side stays gated
        parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1; loop_en = 1'b1;
        rdv_seen = 1'b0;
        fork
            begin
                send(12'hE00, 12);
                send(12'hFFE, 12);
                send(12'hF02, 12);
            end
            begin
                capture(12, obs_a);
                capture(12, obs_b);
                capture(12, obs_c);
            end
            begin
                repeat (700) begin
                    @(negedge clk);
                    if (bus.rd_valid) rdv_seen = 1'b1;
                end
            end
        join
        chk("lb_frame_00", obs_a, 12'hE00);
        chk("lb_frame_FF", obs_b, 12'hFFE);
        chk("lb_frame_81", obs_c, 12'hF02);
        chk("lb_rd_valid_gated", rdv_seen, 0);
        repeat (20) @(negedge clk);
        chk("lb_tx_idle", tx_busy, 0);
        chk("lb_rx_empty", rx_count, 0);
        chk("lb_no_errors", {parity_error, frame_error, overrun_error}, 0);

        // Overrun: 17 frames 8N1 with nobody reading
        loop_en = 1'b0; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            b  = 8'h40 + 8'(k);
            fr = {3'b001, b, 1'b0};
            send(fr, 10);
            if (k == 15) begin
                chk("full_count", rx_count, 16);
                chk("full_no_overrun", overrun_error, 0);
            end
        end
        repeat (4) @(negedge clk);
        chk("ovr_count", rx_count, 16);
        chk("ovr_flag", overrun_error, 1);
        chk("ovr_no_ferr", frame_error, 0);
        for (int k = 0; k < 16; k++) begin
            chk("rd_valid_fill", bus.rd_valid, 1);
            chk("rd_data_order", bus.rd_data, 32'(8'h40 + 8'(k)));
            bus.rd_ready = 1'b1;
            @(negedge clk);
            bus.rd_ready = 1'b0;
        end
        chk("drained_rd_valid", bus.rd_valid, 0);
        chk("drained_count", rx_count, 0);

        // False start: 4-clock low glitch, then a real 0x5A frame
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("errors_cleared", {parity_error, frame_error, overrun_error}, 0);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        chk("false_start_no_push", rx_count, 0);
        chk("false_start_no_err", {parity_error, frame_error, overrun_error}, 0);
        send(12'h2B4, 10);
        repeat (4) @(negedge clk);
        chk("after_glitch_count", rx_count, 1);
        chk("after_glitch_data", bus.rd_data, 8'h5A);
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;

        // Reset in the middle of a TX frame
        bus.wr_valid = 1'b1; bus.wr_data = 8'hC3;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("midframe_busy", tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midframe_rst_tx_out", tx_out, 1);
        chk("midframe_rst_busy", tx_busy, 0);
        repeat (40) @(negedge clk);
        chk("midframe_rst_line_idle", tx_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
